// File: rtl/lcd_display_scheduler_pkg.sv
// Shared types and constants for the LCD display scheduler: opcode values,
// the packed CPU event entry and the scheduler state encoding.
package lcd_display_scheduler_pkg;

    localparam int ENTRY_W = 23;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;
    localparam logic [2:0] OP_DPL   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    // One queued CPU display event, packed {opcode, reg, value}
    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  reg_idx;
        logic [15:0] value;
    } entry_t;

    function automatic entry_t make_entry(input logic [2:0]  opcode,
                                          input logic [3:0]  reg_idx,
                                          input logic [15:0] value);
        entry_t e;
        e.opcode  = opcode;
        e.reg_idx = reg_idx;
        e.value   = value;
        return e;
    endfunction

endpackage

// File: rtl/lcd_display_scheduler_req_fifo.sv
// CPU event queue: synchronous FIFO with show-ahead read data, full/empty
// flags and pointers that wrap modulo DEPTH (DEPTH is a power of two).
module lcd_display_scheduler_req_fifo
    import lcd_display_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_push_data,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_pop_data,
    output logic               o_full,
    output logic               o_empty
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = 1;
    localparam logic [AW-1:0] PTR_ONE    = 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full     = (r_count == FULL_COUNT);
    assign o_empty    = (r_count == '0);
    assign w_push_ok  = i_push & ~o_full;
    assign w_pop_ok   = i_pop & ~o_empty;
    assign o_pop_data = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the reset pointers/count make stale words unreachable.
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/lcd_display_scheduler.sv
// Front-end sequencer for the LCD controller: queues CPU display events,
// gives blank/splash system requests priority, issues one update request at a
// time and keeps each message on screen for a minimum hold time.
module lcd_display_scheduler
    import lcd_display_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 25000,
    parameter int ACK_TIMEOUT = 1023
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [2:0]  cpu_opcode,
    input  logic [3:0]  cpu_reg_idx,
    input  logic [15:0] cpu_value,
    input  logic        sys_splash_req,
    input  logic        sys_blank_req,
    input  logic        lcd_busy,
    output logic        lcd_update_req,
    output logic        lcd_show_splash,
    output logic        lcd_force_blank,
    output logic [2:0]  lcd_opcode,
    output logic [3:0]  lcd_reg_idx,
    output logic [15:0] lcd_value,
    output logic        overflow,
    output logic        timeout_err
);

    localparam int               CNT_MAX   = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
    localparam int               CNT_W     = $clog2(CNT_MAX + 2);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic        r_splash_pend;
    logic        r_blank_pend;
    logic        r_ready_en;
    logic        r_overflow;
    logic        r_timeout;
    logic        r_show_splash;
    logic        r_force_blank;
    logic [2:0]  r_opcode;
    logic [3:0]  r_reg_idx;
    logic [15:0] r_value;

    logic        w_take_blank;
    logic        w_take_splash;
    logic        w_pop;
    logic        w_load;
    logic        w_set_timeout;
    logic        w_push;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    entry_t      w_fifo_head;
    entry_t      w_load_entry;

    // cpu_ready stays low for the cycle following reset, then tracks !full
    assign cpu_ready      = r_ready_en & ~w_fifo_full;
    assign w_push         = cpu_valid & cpu_ready;
    assign w_load_entry   = w_pop ? w_fifo_head : '0;
    assign lcd_update_req = (r_state == ST_ISSUE);

    assign lcd_show_splash = r_show_splash;
    assign lcd_force_blank = r_force_blank;
    assign lcd_opcode      = r_opcode;
    assign lcd_reg_idx     = r_reg_idx;
    assign lcd_value       = r_value;
    assign overflow        = r_overflow;
    assign timeout_err     = r_timeout;

    lcd_display_scheduler_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (make_entry(cpu_opcode, cpu_reg_idx, cpu_value)),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Next-state, counter and winner selection
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_take_blank  = 1'b0;
        w_take_splash = 1'b0;
        w_pop         = 1'b0;
        w_load        = 1'b0;
        w_set_timeout = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!lcd_busy) begin
                    if (r_blank_pend)       w_take_blank  = 1'b1;
                    else if (r_splash_pend) w_take_splash = 1'b1;
                    else if (!w_fifo_empty) w_pop         = 1'b1;
                    w_load = w_take_blank | w_take_splash | w_pop;
                    if (w_load) w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (lcd_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_cnt == ACK_LAST) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!lcd_busy) begin
                    if (HOLD_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt   = HOLD_LOAD;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // A pending blank cuts the hold short
                if (r_blank_pend || r_cnt <= CNT_ONE) w_state_nxt = ST_IDLE;
                else                                  w_cnt_nxt   = r_cnt - CNT_ONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and shared counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Sticky system request flags; a pulse arriving as its flag is consumed stays pending
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blank_pend  <= 1'b0;
            r_splash_pend <= 1'b0;
        end else begin
            r_blank_pend  <= (r_blank_pend  & ~w_take_blank)  | sys_blank_req;
            r_splash_pend <= (r_splash_pend & ~w_take_splash) | sys_splash_req;
        end
    end

    // Controller-facing data, captured only when a request leaves IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_show_splash <= 1'b0;
            r_force_blank <= 1'b0;
            r_opcode      <= '0;
            r_reg_idx     <= '0;
            r_value       <= '0;
        end else if (w_load) begin
            r_show_splash <= w_take_splash;
            r_force_blank <= w_take_blank;
            r_opcode      <= w_load_entry.opcode;
            r_reg_idx     <= w_load_entry.reg_idx;
            r_value       <= w_load_entry.value;
        end
    end

    // Sticky error flags and post-reset ready enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            r_overflow <= r_overflow | (cpu_valid & ~cpu_ready);
            r_timeout  <= r_timeout | w_set_timeout;
        end
    end

endmodule

// File: tb/tb_lcd_display_scheduler.sv
// Self-checking bench for lcd_display_scheduler: a controller model raises
// busy one cycle after each update request and compares the presented data
// against a scoreboard of expected requests.
module tb_lcd_display_scheduler;
    import lcd_display_scheduler_pkg::*;

    localparam int HOLD     = 100;
    localparam int BUSY_LEN = 20;
    localparam int ACK_TO   = 1023;

    localparam logic [24:0] BLANK_WORD  = 25'h100_0000;
    localparam logic [24:0] SPLASH_WORD = 25'h080_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [2:0]  cpu_opcode;
    logic [3:0]  cpu_reg_idx;
    logic [15:0] cpu_value;
    logic        sys_splash_req;
    logic        sys_blank_req;
    logic        lcd_busy = 1'b0;
    logic        lcd_update_req;
    logic        lcd_show_splash;
    logic        lcd_force_blank;
    logic [2:0]  lcd_opcode;
    logic [3:0]  lcd_reg_idx;
    logic [15:0] lcd_value;
    logic        overflow;
    logic        timeout_err;

    always #5 clk = ~clk;

    lcd_display_scheduler #(
        .FIFO_DEPTH  (4),
        .HOLD_CYCLES (HOLD),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_valid       (cpu_valid),
        .cpu_ready       (cpu_ready),
        .cpu_opcode      (cpu_opcode),
        .cpu_reg_idx     (cpu_reg_idx),
        .cpu_value       (cpu_value),
        .sys_splash_req  (sys_splash_req),
        .sys_blank_req   (sys_blank_req),
        .lcd_busy        (lcd_busy),
        .lcd_update_req  (lcd_update_req),
        .lcd_show_splash (lcd_show_splash),
        .lcd_force_blank (lcd_force_blank),
        .lcd_opcode      (lcd_opcode),
        .lcd_reg_idx     (lcd_reg_idx),
        .lcd_value       (lcd_value),
        .overflow        (overflow),
        .timeout_err     (timeout_err)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [24:0] sb_q[$];

    int          cyc = 0;
    bit          force_busy  = 1'b1;
    bit          respond     = 1'b1;
    bit          start_pend  = 1'b0;
    bit          from_force  = 1'b0;
    bit          skip_stable = 1'b0;
    int          busy_left   = 0;
    int          req_cnt     = 0;
    int          last_req_cyc = 0;
    int          fall_cyc    = 0;
    logic [24:0] cap_word    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [24:0] lcd_word();
        return {lcd_force_blank, lcd_show_splash, lcd_opcode, lcd_reg_idx, lcd_value};
    endfunction

    function automatic logic [24:0] cpu_word(input logic [2:0] op, input logic [3:0] r, input logic [15:0] v);
        return {2'b00, op, r, v};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: busy rises one cycle after update_req and lasts BUSY_LEN cycles
    always @(negedge clk) begin
        if (force_busy) begin
            lcd_busy   = 1'b1;
            from_force = 1'b1;
            start_pend = 1'b0;
        end else if (start_pend) begin
            start_pend = 1'b0;
            lcd_busy   = 1'b1;
            busy_left  = BUSY_LEN;
            cap_word   = lcd_word();
            check("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) check("issue_data", 32'(cap_word), 32'(sb_q.pop_front()));
        end else if (lcd_busy) begin
            if (from_force) begin
                lcd_busy   = 1'b0;
                from_force = 1'b0;
            end else if (busy_left <= 1) begin
                if (skip_stable) skip_stable = 1'b0;
                else             check("data_stable", 32'(lcd_word()), 32'(cap_word));
                lcd_busy = 1'b0;
                fall_cyc = cyc + 1;
            end else begin
                busy_left--;
            end
        end
        if (lcd_update_req) begin
            req_cnt++;
            last_req_cyc = cyc;
            if (respond) start_pend = 1'b1;
        end
    end

    task automatic drive_cpu(input logic [2:0] op, input logic [3:0] r, input logic [15:0] v,
                             input bit exp_ready, input bit to_sb);
        @(negedge clk);
        cpu_valid   = 1'b1;
        cpu_opcode  = op;
        cpu_reg_idx = r;
        cpu_value   = v;
        check("cpu_ready", 32'(cpu_ready), 32'(exp_ready));
        if (exp_ready && to_sb) sb_q.push_back(cpu_word(op, r, v));
    endtask

    task automatic idle_cpu();
        @(negedge clk);
        cpu_valid = 1'b0;
    endtask

    task automatic pulse_sys(input bit blank, input bit splash);
        @(negedge clk);
        sys_blank_req  = blank;
        sys_splash_req = splash;
        @(negedge clk);
        sys_blank_req  = 1'b0;
        sys_splash_req = 1'b0;
    endtask

    task automatic settle(input string tag);
        int n = 0;
        while ((sb_q.size() != 0 || lcd_busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 4000), 32'd1);
        repeat (HOLD + 10) @(negedge clk);
    endtask

    task automatic wait_req(input int target, input int limit, input string tag);
        int n = 0;
        while (req_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(req_cnt), 32'(target));
    endtask

    task automatic wait_busy(input bit lvl, input string tag);
        int n = 0;
        while (lcd_busy !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(lcd_busy), 32'(lvl));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int d;
        int p;
        int n;
        rst_n          = 1'b0;
        cpu_valid      = 1'b0;
        cpu_opcode     = '0;
        cpu_reg_idx    = '0;
        cpu_value      = '0;
        sys_splash_req = 1'b0;
        sys_blank_req  = 1'b0;

        // 1: reset with the controller busy through init, then one ADD event
        repeat (3) @(negedge clk);
        check("rst_update_req", 32'(lcd_update_req), 32'd0);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_lcd_word", 32'(lcd_word()), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cpu_ready), 32'd1);
        drive_cpu(OP_ADD, 4'd3, 16'd42, 1'b1, 1'b1);
        idle_cpu();
        repeat (500) @(negedge clk);
        check("no_req_while_busy", 32'(req_cnt), 32'd0);
        force_busy = 1'b0;
        settle("t1_settle");
        check("t1_req_count", 32'(req_cnt), 32'd1);

        // 2: five back-to-back events into a depth-4 queue while busy
        @(negedge clk);
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++)
            drive_cpu(3'(i), 4'(i + 5), 16'(i * 300 - 500), i < 4, 1'b1);
        idle_cpu();
        check("full_ready", 32'(cpu_ready), 32'd0);
        check("overflow_set", 32'(overflow), 32'd1);
        force_busy = 1'b0;
        settle("t2_settle");
        check("t2_req_count", 32'(req_cnt), 32'd5);

        // 3: two queued events, then splash+blank together and a repeated splash
        @(negedge clk);
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        drive_cpu(OP_CLEAR, 4'd1, 16'h0000, 1'b1, 1'b0);
        drive_cpu(OP_SUB, 4'd15, 16'hFFF6, 1'b1, 1'b0);
        idle_cpu();
        pulse_sys(1'b1, 1'b1);
        pulse_sys(1'b0, 1'b1);
        sb_q.push_back(BLANK_WORD);
        sb_q.push_back(SPLASH_WORD);
        sb_q.push_back(cpu_word(OP_CLEAR, 4'd1, 16'h0000));
        sb_q.push_back(cpu_word(OP_SUB, 4'd15, 16'hFFF6));
        force_busy = 1'b0;
        settle("t3_settle");
        check("t3_req_count", 32'(req_cnt), 32'd9);

        // 4: hold spacing after busy falls, and blank preempting a hold
        base = req_cnt;
        drive_cpu(OP_OR, 4'd7, 16'h1234, 1'b1, 1'b1);
        drive_cpu(OP_DPL, 4'd8, 16'h8000, 1'b1, 1'b1);
        idle_cpu();
        wait_req(base + 2, 1000, "t4_second_req");
        d = last_req_cyc - fall_cyc;
        check("hold_spacing", 32'(d >= HOLD && d <= HOLD + 2), 32'd1);
        wait_busy(1'b1, "t4_busy_rise");
        wait_busy(1'b0, "t4_busy_fall");
        repeat (50) @(negedge clk);
        @(negedge clk);
        sys_blank_req = 1'b1;
        p = cyc;
        sb_q.push_back(BLANK_WORD);
        @(negedge clk);
        sys_blank_req = 1'b0;
        wait_req(base + 3, 20, "t4_blank_req");
        d = last_req_cyc - p;
        check("blank_preempt_latency", 32'(d >= 1 && d <= 3), 32'd1);
        settle("t4_settle");

        // 5: controller never acknowledges -> timeout, then recovery
        respond = 1'b0;
        base    = req_cnt;
        drive_cpu(OP_MUL, 4'd2, 16'h00FF, 1'b1, 1'b0);
        idle_cpu();
        wait_req(base + 1, 50, "t5_req");
        p = last_req_cyc;
        repeat (2) @(negedge clk);
        check("t5_issue_data", 32'(lcd_word()), 32'(cpu_word(OP_MUL, 4'd2, 16'h00FF)));
        n = 0;
        while (!timeout_err && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_set", 32'(timeout_err), 32'd1);
        d = cyc - p;
        check("timeout_latency", 32'(d >= ACK_TO && d <= ACK_TO + 2), 32'd1);
        respond = 1'b1;
        drive_cpu(OP_LOAD, 4'd9, 16'h7FFF, 1'b1, 1'b1);
        idle_cpu();
        settle("t5_settle");
        check("t5_req_count", 32'(req_cnt), 32'(base + 2));
        check("timeout_sticky", 32'(timeout_err), 32'd1);

        // 6: reset during WAIT_DONE with more events queued
        base = req_cnt;
        drive_cpu(OP_AND, 4'd12, 16'hBEEF, 1'b1, 1'b1);
        idle_cpu();
        wait_busy(1'b1, "t6_busy_rise");
        repeat (2) @(negedge clk);
        drive_cpu(OP_ADD, 4'd4, 16'd1, 1'b1, 1'b0);
        drive_cpu(OP_ADD, 4'd5, 16'd2, 1'b1, 1'b0);
        idle_cpu();
        check("overflow_sticky", 32'(overflow), 32'd1);
        skip_stable = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_update_req", 32'(lcd_update_req), 32'd0);
        check("t6_lcd_word", 32'(lcd_word()), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        check("t6_timeout", 32'(timeout_err), 32'd0);
        check("t6_cpu_ready", 32'(cpu_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready_after", 32'(cpu_ready), 32'd1);
        repeat (300) @(negedge clk);
        check("t6_fifo_flushed", 32'(req_cnt), 32'(base + 1));
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
